fx_control_core: RTL

Parametrised control core for the effects pedal, on i_AUD_BCLK. Conditions the three push-buttons (synchroniser, debounce, one pulse per press). Runs the mode FSM (I2C init / play / set / loop-record / loop-play) and holds a bank of NUM_FX effect levels, adjustable up or down with wrap or saturate. Drives the level bus into the effect chain, the loop-engine enables and the LED/HEX indicators.

---
 rtl/fx_ctrl_pkg.sv | 42 ++++
 rtl/fx_control_core_key_conditioner.sv | 41 ++++
 rtl/fx_control_core.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fx_ctrl_pkg.sv
// Shared types and constants for the effects pedal control core.
// State codes, LED encodings and effect slot indices.
package fx_ctrl_pkg;

    typedef enum logic [2:0] {
        S_I2C  = 3'd0,
        S_PLAY = 3'd1,
        S_SET  = 3'd2,
        S_RECD = 3'd3,
        S_LOOP = 3'd4
    } state_e;

    localparam logic [8:0] LEDG_I2C  = 9'h100;
    localparam logic [8:0] LEDG_PLAY = 9'h001;
    localparam logic [8:0] LEDG_SET  = 9'h002;
    localparam logic [8:0] LEDG_RECD = 9'h004;
    localparam logic [8:0] LEDG_LOOP = 9'h008;

    localparam int FX_GATE = 0;
    localparam int COMP    = 1;
    localparam int DIST    = 2;
    localparam int EQ_B    = 3;
    localparam int EQ_T    = 4;
    localparam int TREM    = 5;
    localparam int CHOR    = 6;
    localparam int DEL     = 7;

    function automatic logic [8:0] ledg_of(input logic [2:0] s);
        logic [8:0] r;
        r = 9'h000;
        unique case (s)
            S_I2C:   r = LEDG_I2C;
            S_PLAY:  r = LEDG_PLAY;
            S_SET:   r = LEDG_SET;
            S_RECD:  r = LEDG_RECD;
            S_LOOP:  r = LEDG_LOOP;
            default: r = 9'h000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fx_control_core_key_conditioner.sv
// Push-button conditioner: 2-FF sync, debounce counter,
// one single-cycle pulse per accepted press.
module key_conditioner #(
    parameter int DEB_CYC = 30000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic pulse_o
);

    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] PRE  = CW'(DEB_CYC - 2);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    // Counter parks at LAST while held, so only the PRE->LAST step fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= key_raw_i;
            sync_q  <= meta_q;
            pulse_q <= sync_q && (cnt_q == PRE);
            if (!sync_q)
                cnt_q <= '0;
            else if (cnt_q != LAST)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/fx_control_core.sv
// Effects pedal control core: key conditioning, mode FSM,
// effect level bank and indicator outputs.
module fx_control_core #(
    parameter int NUM_FX  = 8,
    parameter int LVL_W   = 3,
    parameter int DEB_CYC = 30000,
    parameter int WRAP    = 1,
    parameter logic [NUM_FX*LVL_W-1:0] RESET_LVL = 24'o00044002,
    localparam int SEL_W  = $clog2(NUM_FX)
) (
    input  logic                    i_AUD_BCLK,
    input  logic                    i_rst_n,
    input  logic                    i_i2c_done,
    input  logic                    i_key_val,
    input  logic                    i_key_loop,
    input  logic                    i_key_mode,
    input  logic                    i_dir,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [NUM_FX-1:0]       i_en,
    input  logic                    i_loop_full,
    output logic [2:0]              o_state,
    output logic [NUM_FX*LVL_W-1:0] o_levels,
    output logic [NUM_FX-1:0]       o_fx_en,
    output logic                    o_rec_en,
    output logic                    o_play_en,
    output logic                    o_loop_clr,
    output logic [8:0]              o_ledg,
    output logic [NUM_FX-1:0]       o_ledr,
    output logic [LVL_W-1:0]        o_cur_val
);

    import fx_ctrl_pkg::*;

    localparam logic [LVL_W-1:0]  LMAX   = '1;
    localparam logic [SEL_W:0]    NFX_W  = (SEL_W + 1)'(NUM_FX);
    localparam logic [NUM_FX-1:0] ONE_FX = NUM_FX'(1);

    logic              i2c_m_q, i2c_s_q;
    logic              dir_m_q, dir_s_q;
    logic [SEL_W-1:0]  sel_m_q, sel_s_q;
    logic [NUM_FX-1:0] en_m_q, en_s_q;
    logic              val_p, loop_p, mode_p;
    state_e            state_q, state_d;
    logic              clr_q;
    logic [LVL_W-1:0]  lvl_q [NUM_FX];
    logic              sel_ok, upd;
    logic [LVL_W-1:0]  lvl_sel;

    key_conditioner #(.DEB_CYC(DEB_CYC)) u_key_val (
        .clk(i_AUD_BCLK), .rst_n(i_rst_n), .key_raw_i(i_key_val), .pulse_o(val_p)
    );
    key_conditioner #(.DEB_CYC(DEB_CYC)) u_key_loop (
        .clk(i_AUD_BCLK), .rst_n(i_rst_n), .key_raw_i(i_key_loop), .pulse_o(loop_p)
    );
    key_conditioner #(.DEB_CYC(DEB_CYC)) u_key_mode (
        .clk(i_AUD_BCLK), .rst_n(i_rst_n), .key_raw_i(i_key_mode), .pulse_o(mode_p)
    );

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            i2c_m_q <= 1'b0;
            i2c_s_q <= 1'b0;
            dir_m_q <= 1'b0;
            dir_s_q <= 1'b0;
            sel_m_q <= '0;
            sel_s_q <= '0;
            en_m_q  <= '0;
            en_s_q  <= '0;
        end else begin
            i2c_m_q <= i_i2c_done;
            i2c_s_q <= i2c_m_q;
            dir_m_q <= i_dir;
            dir_s_q <= dir_m_q;
            sel_m_q <= i_sel;
            sel_s_q <= sel_m_q;
            en_m_q  <= i_en;
            en_s_q  <= en_m_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_I2C:   if (i2c_s_q) state_d = S_PLAY;
            S_PLAY:  if (loop_p) state_d = S_RECD;
                     else if (mode_p) state_d = S_SET;
            S_SET:   if (mode_p) state_d = S_PLAY;
            S_RECD:  if (loop_p || i_loop_full) state_d = S_LOOP;
            S_LOOP:  if (loop_p) state_d = S_PLAY;
            default: state_d = S_PLAY;
        endcase
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_I2C;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= (state_d == S_RECD) && (state_q != S_RECD);
        end
    end

    function automatic logic [LVL_W-1:0] step(input logic [LVL_W-1:0] v,
                                              input logic dn);
        logic [LVL_W-1:0] r;
        if (!dn)
            r = (v == LMAX) ? ((WRAP != 0) ? '0 : LMAX) : v + LVL_W'(1);
        else
            r = (v == '0) ? ((WRAP != 0) ? LMAX : '0) : v - LVL_W'(1);
        return r;
    endfunction

    assign sel_ok  = {1'b0, sel_s_q} < NFX_W;
    assign upd     = (state_q == S_SET) && val_p && sel_ok;
    assign lvl_sel = sel_ok ? lvl_q[sel_s_q] : '0;

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_FX; i++)
                lvl_q[i] <= RESET_LVL[i*LVL_W +: LVL_W];
        end else if (upd) begin
            lvl_q[sel_s_q] <= step(lvl_q[sel_s_q], dir_s_q);
        end
    end

    for (genvar g = 0; g < NUM_FX; g++) begin : g_lv
        assign o_levels[g*LVL_W +: LVL_W] = lvl_q[g];
    end

    assign o_state    = state_q;
    assign o_fx_en    = en_s_q;
    assign o_rec_en   = (state_q == S_RECD);
    assign o_play_en  = (state_q == S_LOOP);
    assign o_loop_clr = clr_q;
    assign o_ledg     = ledg_of(state_q);
    assign o_ledr     = (state_q != S_SET) ? en_s_q :
                        sel_ok ? (ONE_FX << sel_s_q) : '0;
    assign o_cur_val  = (state_q == S_SET) ? lvl_sel : '0;

endmodule
